// File: rtl/heichips25_template.sv
// heichips25_template: complex I/Q conjugate-product moving-window correlator.
// Define HEICHIPS25_SAT_EN to saturate the scaled sums; otherwise they wrap.
module heichips25_template #(
   parameter int WINDOW = 4,
   parameter int SHIFT  = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int LW = $clog2(WINDOW);
   localparam int SW = 9 + LW;

   logic signed [3:0] i1, q1, i2, q2;
   logic signed [8:0] prod_re, prod_im;
   logic signed [8:0] tap_re [WINDOW];
   logic signed [8:0] tap_im [WINDOW];
   logic signed [SW-1:0] sum_re, sum_im;

   assign uio_oe = 8'h00;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         i1 <= '0;
         q1 <= '0;
         i2 <= '0;
         q2 <= '0;
      end else if (ena) begin
         i1 <= ui_in[3:0];
         q1 <= ui_in[7:4];
         i2 <= uio_in[7:4];
         q2 <= uio_in[3:0];
      end
   end

   // 9-bit operands keep the full -112..128 range of each product sum
   assign prod_re = 9'(i1) * 9'(i2) + 9'(q1) * 9'(q2);
   assign prod_im = 9'(q1) * 9'(i2) - 9'(i1) * 9'(q2);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < WINDOW; i++) begin
            tap_re[i] <= '0;
            tap_im[i] <= '0;
         end
      end else if (ena) begin
         tap_re[0] <= prod_re;
         tap_im[0] <= prod_im;
         for (int i = 1; i < WINDOW; i++) begin
            tap_re[i] <= tap_re[i-1];
            tap_im[i] <= tap_im[i-1];
         end
      end
   end

   always_comb begin
      sum_re = '0;
      sum_im = '0;
      for (int i = 0; i < WINDOW; i++) begin
         sum_re = sum_re + SW'(tap_re[i]);
         sum_im = sum_im + SW'(tap_im[i]);
      end
   end

   function automatic logic [7:0] scale(input logic signed [SW-1:0] s);
      logic signed [SW-1:0] sh;
      sh = s >>> SHIFT;
`ifdef HEICHIPS25_SAT_EN
      if (sh > SW'(127))
         return 8'h7F;
      else if (sh < SW'(-128))
         return 8'h80;
      else
         return 8'(sh);
`else
      return 8'(sh);
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (rst_n) begin
         uo_out  <= 8'h00;
         uio_out <= 8'h00;
      end else if (ena) begin
         uo_out  <= scale(sum_re);
         uio_out <= scale(sum_im);
      end
   end

endmodule

// File: tb/tb_heichips25_template.sv
// Directed self-checking bench for heichips25_template (default parameters).
// The saturation vector expects 8'h7F when HEICHIPS25_SAT_EN is defined.
module tb_heichips25_template;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int vectors = 0;
   int errors  = 0;

   logic [7:0] ramp [11];
   logic [7:0] sat_exp;

   heichips25_template dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      ramp = '{8'h00, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
               8'h10, 8'h0C, 8'h08, 8'h04, 8'h00};
`ifdef HEICHIPS25_SAT_EN
      sat_exp = 8'h7F;
`else
      sat_exp = 8'h00;
`endif

      // reset with non-zero inputs
      rst_n  = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h55;
      uio_in = 8'h33;
      tick();
      chk("rst_oe_mid", uio_oe, 8'h00);
      tick();
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
      chk("rst_oe", uio_oe, 8'h00);

      // constant real stream, 5 samples then zeros
      rst_n = 1'b0;
      for (int e = 0; e < 11; e++) begin
         if (e < 5) begin
            ui_in  = 8'h20;
            uio_in = 8'h02;
         end else begin
            ui_in  = 8'h00;
            uio_in = 8'h00;
         end
         tick();
         chk($sformatf("ramp_uo_%0d", e + 1), uo_out, ramp[e]);
         chk($sformatf("ramp_uio_%0d", e + 1), uio_out, 8'h00);
      end

      // imaginary sign: im = -1 per sample
      ui_in  = 8'h01;
      uio_in = 8'h01;
      for (int e = 0; e < 6; e++) tick();
      chk("imag_uio", uio_out, 8'hFC);
      chk("imag_uo", uo_out, 8'h00);
      tick();
      chk("imag_uio_hold", uio_out, 8'hFC);

      // saturation: re = 128 per sample, window sum 512
      ui_in  = 8'h88;
      uio_in = 8'h88;
      for (int e = 0; e < 6; e++) tick();
      chk("sat_uo", uo_out, sat_exp);
      chk("sat_uio", uio_out, 8'h00);

      // clear, then restart the real stream
      rst_n = 1'b1;
      tick();
      chk("clr_uo", uo_out, 8'h00);
      rst_n  = 1'b0;
      ui_in  = 8'h20;
      uio_in = 8'h02;
      tick();
      chk("run_uo_1", uo_out, 8'h00);
      tick();
      chk("run_uo_2", uo_out, 8'h00);
      tick();
      chk("run_uo_3", uo_out, 8'h04);

      // ena low with changed inputs: everything freezes
      ena    = 1'b0;
      ui_in  = 8'h77;
      uio_in = 8'h77;
      for (int e = 0; e < 3; e++) begin
         tick();
         chk($sformatf("hold_uo_%0d", e), uo_out, 8'h04);
         chk($sformatf("hold_uio_%0d", e), uio_out, 8'h00);
      end

      ena    = 1'b1;
      ui_in  = 8'h20;
      uio_in = 8'h02;
      tick();
      chk("resume_uo_1", uo_out, 8'h08);
      tick();
      chk("resume_uo_2", uo_out, 8'h0C);
      tick();
      chk("resume_uo_3", uo_out, 8'h10);

      // one-edge reset mid-stream
      rst_n = 1'b1;
      tick();
      chk("mid_rst_uo", uo_out, 8'h00);
      chk("mid_rst_uio", uio_out, 8'h00);
      rst_n = 1'b0;
      tick();
      chk("refill_uo_1", uo_out, 8'h00);
      tick();
      chk("refill_uo_2", uo_out, 8'h00);
      tick();
      chk("refill_uo_3", uo_out, 8'h04);
      tick();
      chk("refill_uo_4", uo_out, 8'h08);
      chk("final_oe", uio_oe, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/heichips25_template.md
# heichips25_template

Complex I/Q correlator front end for the heichips25 SDR tile. Each cycle it takes two 4-bit signed complex samples, s1 = I1 + jQ1 and s2 = I2 + jQ2, and forms the conjugate dot product s1·conj(s2). It keeps a moving-window sum of the last WINDOW products and drives the scaled real part on uo_out and the imaginary part on uio_out. The block sits directly behind the tile pin mux; all uio pins are used as inputs.

## Interface
Parameters:
- WINDOW, default 4: moving-sum length in samples; power of two, 1..16.
- SHIFT, default 0: arithmetic right shift (0..7) applied to the window sums before output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous and active-high (asserted when 1), despite the port name.
- ena  input  1  sample enable; when 0, all pipeline state holds.
- ui_in  input  8  {Q1[3:0], I1[3:0]}, two's complement.
- uio_in  input  8  {I2[3:0], Q2[3:0]}, two's complement.
- uo_out  output  8  signed real part of the scaled window sum.
- uio_out  output  8  signed imaginary part of the scaled window sum.
- uio_oe  output  8  constant 8'h00; all uio pins are inputs.

## Operation
- Input decode: I1 = ui_in[3:0], Q1 = ui_in[7:4], I2 = uio_in[7:4], Q2 = uio_in[3:0]. Each field is signed 4-bit, range -8..7.
- Product per sample:
  - re = I1·I2 + Q1·Q2
  - im = Q1·I2 − I1·Q2
  - Both are computed at 9 bits signed (range −112..128), with no overflow.
- Delay line: WINDOW taps each for re and im. Each enabled cycle, the new product enters tap0 and the oldest product is discarded.
- Window sums: sum_re and sum_im are the sums of all taps, computed at 9+log2(WINDOW) bits signed with no overflow.
- Scaling: each sum is arithmetically shifted right by SHIFT, then reduced to 8 bits per Configuration. The result is registered to uo_out and uio_out.
- ena = 0: input, product and output registers all hold, and the outputs stay stable.
- Reset: clears the input registers, all taps and both output registers to 0. Reset has priority over ena. Asserting reset mid-stream discards all in-flight samples. After release, the window refills from zero.
- uio_oe is tied to 8'h00 at all times, including during reset.

## Timing
- Reset values: uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'h00.
- Pipeline stages:
  - Edge k: ui_in and uio_in are registered (requires ena = 1).
  - Edge k+1: the product enters tap0.
  - Edge k+2: the output registers update from the new window sum.
- Latency: a sample presented before edge k first affects the outputs after edge k+2, which is 3 enabled cycles.
- A constant input stream fully fills the window after WINDOW+2 enabled edges.
- Switching to zero inputs drains the outputs to 0 after WINDOW+2 enabled edges.
- There is no handshake and no valid output; every enabled cycle consumes one sample pair.

## Configuration
- HEICHIPS25_SAT_EN defined: each scaled sum saturates to the signed 8-bit range, −128..127 (8'h80..8'h7F).
- HEICHIPS25_SAT_EN undefined: each scaled sum wraps, so the output is the low 8 bits of the two's-complement value.
- The saturating build is the tapeout configuration. Both builds must pass every test below except the one marked.

## Test plan
- Reset: hold rst_n = 1 for 2 edges with non-zero inputs -> uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'h00.
- Constant real, default parameters: I1 = 0, Q1 = 2, I2 = 0, Q2 = 2 (ui_in = 8'h20, uio_in = 8'h02) for 5 cycles, then zeros.
  - uo_out steps 04, 08, 0C, 10 starting 3 edges after the first sample.
  - After the zeros, uo_out drains back to 00 within 6 edges.
  - uio_out stays 00 throughout.
- Imaginary sign: I1 = 1, Q2 = 1, others 0 (im = −1) held -> uio_out settles at 8'hFC, uo_out = 00.
- Saturation: all four fields = −8 (ui_in = 8'h88, uio_in = 8'h88) held, giving re = 128 per sample and sum 512.
  - HEICHIPS25_SAT_EN defined: uo_out = 8'h7F.
  - HEICHIPS25_SAT_EN undefined: uo_out = 8'h00. This is the one case that differs between builds.
  - uio_out = 00 in both builds.
- ena hold: during the constant-real stream, drop ena for 3 cycles while changing the inputs.
  - Outputs freeze for those 3 cycles.
  - The changed inputs are ignored.
  - Output progression resumes exactly where it left off.
- Reset mid-stream: assert rst_n for one edge while uo_out = 8'h10.
  - Next cycle the outputs are 00.
  - The refill sequence then restarts from 04.
